spi_cursor_ctrl: RTL
====================

# spi_cursor_ctrl

Controller that sequences cursor-position frames from the PIC's SPI link into the VGA clock domain. It oversamples `sclk`/`sdi` on the system clock, frames 32-bit words, and recovers framing with a watchdog because the link has no chip select. It clamps positions to the visible screen and commits them only during vertical blanking, so the cursor never tears mid-frame. Its outputs feed the cursor overlay in the VGA pipeline.

## Interface
- `H_MAX`, 640, visible width; x is clamped to `H_MAX-1`.
- `V_MAX`, 480, visible height; y is clamped to `V_MAX-1`.
- `TIMEOUT`, 1024, number of idle `clk` cycles mid-frame that aborts the frame.

Ports:
- `clk` in 1: system/VGA clock, the only clock.
- `reset` in 1: asynchronous, active-high.
- `sclk` in 1: SPI clock from the PIC, asynchronous to `clk`.
- `sdi` in 1: SPI data from the PIC, MSB first.
- `vblank` in 1: high during vertical blanking (in the `clk` domain).
- `xcursor` out 16: committed, clamped x position.
- `ycursor` out 16: committed, clamped y position.
- `frame_ok` out 1: one-cycle pulse on each commit.
- `frame_err` out 1: one-cycle pulse when a partial frame is aborted by timeout.
- `frame_drop` out 1: one-cycle pulse when an uncommitted pending frame is overwritten.
- `busy` out 1: high while the receive FSM is in SHIFT.

## Operation
- Synchronizers:
  - `sclk` and `sdi` each pass through a 2-FF synchronizer.
  - A third `sclk` stage provides edge detect.
  - A sample event `se` fires on a synchronized `sclk` falling edge; it captures the synchronized `sdi`.
- Receive FSM:
  - IDLE: `bitcnt`=0, `tocnt`=0.
    - On `se`, shift in the bit, set `bitcnt`=1, and go to SHIFT.
  - SHIFT: each `se` does `shreg <= {shreg[30:0], sdi_s}`, increments `bitcnt`, and clears `tocnt`.
    - Without `se`, `tocnt` increments.
    - On the `se` that makes `bitcnt`=32, load `pend <= {shreg[30:0], sdi_s}` and set `pend_v`, then return to IDLE.
    - If `tocnt` reaches `TIMEOUT-1` with no `se`, discard the frame, pulse `frame_err`, and go to IDLE.
- Word format: `pend[31:16]` is x and `pend[15:0]` is y. Both are unsigned.
- Commit FSM:
  - EMPTY: wait for `pend_v`, then go to PENDING.
  - PENDING: when `vblank`=1, load the outputs, pulse `frame_ok`, clear `pend_v`, and go to EMPTY.
    - `xcursor <= (x >= H_MAX) ? H_MAX-1 : x`.
    - `ycursor <= (y >= V_MAX) ? V_MAX-1 : y`.
- Latest frame wins: a new frame that completes while PENDING replaces `pend` and pulses `frame_drop`.
- Counter widths:
  - `bitcnt` is 6 bits and never wraps.
  - `tocnt` is `$clog2(TIMEOUT)` bits and saturates (no wrap).

## Timing
- Reset values: `xcursor`=0, `ycursor`=0, all pulse outputs 0, `busy`=0, `pend_v`=0. Both FSMs reset to IDLE and EMPTY.
- Reset mid-frame or mid-pending discards all partial and pending data.
- Input requirement: `sclk` high and low each for at least 4 `clk` periods. `sdi` stable from 1 cycle before to 3 cycles after the falling edge of `sclk` at the pin.
- The `se` event is asserted on the 3rd `clk` edge after the pin-level `sclk` fall.
- `pend_v` rises the cycle after the 32nd `se`.
- Commit latency:
  - If `vblank` is already high, the outputs and `frame_ok` update 1 cycle after `pend_v`.
  - Otherwise they update 1 cycle after the first `vblank`=1 sample.
- Outputs are registered. `frame_ok` is high in the same cycle the new `xcursor`/`ycursor` first appear.
- Simultaneous new-frame completion and commit in the same cycle:
  - The old `pend` commits (`frame_ok`).
  - The new word becomes pending (`pend_v` stays 1).
  - No `frame_drop` is pulsed.
- A timeout and a final `se` in the same cycle count as the `se`; no error is flagged.
- `busy` is high from the cycle after the first `se` until the cycle after frame completion or abort.

## Test plan
- Commit in vblank:
  - Stimulus: `vblank`=1; shift `0x0064_00C8` MSB first with an 8-cycle `sclk` period.
  - Required: `xcursor`=100, `ycursor`=200, and one `frame_ok` pulse, 1 cycle after `pend_v`.
- Clamping:
  - Stimulus: send `0xFFFF_01E0`.
  - Required: `xcursor`=639 and `ycursor`=479.
- Commit deferral:
  - Stimulus: `vblank`=0 during the frame; raise `vblank` 50 cycles later.
  - Required: outputs unchanged until then, and they update 1 cycle after `vblank` rises.
- Drop:
  - Stimulus: with `vblank`=0, send `0x0001_0001` then `0x0002_0002`; then assert `vblank`.
  - Required: one `frame_drop` pulse; committed x=2, y=2; exactly one `frame_ok`.
- Timeout resync:
  - Stimulus: send 20 bits; idle for 1024 cycles; then send `0x0010_0020`.
  - Required: one `frame_err` pulse, then x=16, y=32.
- Reset mid-frame:
  - Stimulus: assert `reset` after 10 bits, release it, then send a full frame.
  - Required: all outputs 0 during reset, then correct decode of the new frame.

Source files
------------

// File: rtl/spi_cursor_if.sv
// Cursor-link bundle: raw SPI pins and vblank in, committed cursor
// position and frame status pulses out.
interface spi_cursor_if;
    logic        sclk;
    logic        sdi;
    logic        vblank;
    logic [15:0] xcursor;
    logic [15:0] ycursor;
    logic        frame_ok;
    logic        frame_err;
    logic        frame_drop;
    logic        busy;

    modport master (
        output sclk, sdi, vblank,
        input  xcursor, ycursor,
        input  frame_ok, frame_err, frame_drop, busy
    );

    modport slave (
        input  sclk, sdi, vblank,
        output xcursor, ycursor,
        output frame_ok, frame_err, frame_drop, busy
    );
endinterface

// File: rtl/spi_cursor_ctrl.sv
// Receives 32-bit cursor words over a chip-select-less SPI link and
// commits clamped x/y to the VGA domain during vertical blanking.
module spi_cursor_ctrl #(
    parameter int H_MAX   = 640,
    parameter int V_MAX   = 480,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    spi_cursor_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TOLIM = TW'(TIMEOUT - 1);
    localparam logic [15:0]   XLIM  = 16'(H_MAX);
    localparam logic [15:0]   YLIM  = 16'(V_MAX);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic s1, s2, s3;
    logic d1, d2;
    logic se;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            s1 <= bus.sclk;
            s2 <= s1;
            s3 <= s2;
            d1 <= bus.sdi;
            d2 <= d1;
        end
    end

    // Sample on the synchronized falling edge of sclk.
    assign se = s3 & ~s2;

    logic [0:0]    rstate;
    logic [5:0]    bitcnt;
    logic [TW-1:0] tocnt;
    logic [30:0]   shreg;
    logic [31:0]   word;
    logic          done;
    logic          err_q;

    assign word = {shreg, d2};
    assign done = (rstate == S_SHIFT) && se && (bitcnt == 6'd31);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate <= S_IDLE;
            bitcnt <= '0;
            tocnt  <= '0;
            shreg  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (rstate)
                S_IDLE: begin
                    bitcnt <= '0;
                    tocnt  <= '0;
                    if (se) begin
                        shreg  <= word[30:0];
                        bitcnt <= 6'd1;
                        rstate <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (se) begin
                        shreg  <= word[30:0];
                        bitcnt <= bitcnt + 6'd1;
                        tocnt  <= '0;
                        if (bitcnt == 6'd31)
                            rstate <= S_IDLE;
                    end else if (tocnt == TOLIM) begin
                        // Lost framing: drop the partial word and resync.
                        err_q  <= 1'b1;
                        bitcnt <= '0;
                        tocnt  <= '0;
                        rstate <= S_IDLE;
                    end else begin
                        tocnt <= tocnt + TW'(1);
                    end
                end
                default: rstate <= S_IDLE;
            endcase
        end
    end

    logic [31:0] pend;
    logic        pend_v;
    logic        commit;
    logic [15:0] px, py;
    logic [15:0] xq, yq;
    logic        ok_q, drop_q;

    assign px     = pend[31:16];
    assign py     = pend[15:0];
    assign commit = pend_v && bus.vblank;

    // pend_v doubles as the commit state: 0 = EMPTY, 1 = PENDING.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= '0;
            pend_v <= 1'b0;
            xq     <= '0;
            yq     <= '0;
            ok_q   <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            ok_q   <= 1'b0;
            drop_q <= 1'b0;
            if (commit) begin
                xq   <= (px >= XLIM) ? XLIM - 16'd1 : px;
                yq   <= (py >= YLIM) ? YLIM - 16'd1 : py;
                ok_q <= 1'b1;
            end
            if (done) begin
                pend   <= word;
                pend_v <= 1'b1;
                drop_q <= pend_v && !commit;
            end else if (commit) begin
                pend_v <= 1'b0;
            end
        end
    end

    assign bus.xcursor    = xq;
    assign bus.ycursor    = yq;
    assign bus.frame_ok   = ok_q;
    assign bus.frame_err  = err_q;
    assign bus.frame_drop = drop_q;
    assign bus.busy       = (rstate == S_SHIFT);
endmodule
